rob_multiport: RTL and testbench
================================

# rob_multiport

Parametrised reorder buffer for the SSOOO core. It holds DEPTH in-flight instructions in program order and accepts results from NCDB common-data-bus channels per cycle. It exposes two operand read ports to rename/issue and retires one instruction per cycle. On a mispredicted branch reaching the head it raises a single-cycle flush with the redirect address.

## Interface
Parameters:
- DEPTH, 16: number of entries; must be a power of two, minimum 4.
- TAG_W, 5: tag width; must satisfy 2^TAG_W > DEPTH. Tags are 1..DEPTH; tag 0 means "no producer".
- NCDB, 2: number of CDB write channels.
- DATA_W, 32: result/address width.
- OPC_W, 12: opcode width.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  high when count < DEPTH.
- disp_tag  out  TAG_W  tag assigned to the current dispatch (tail index + 1).
- disp_opcode  in  OPC_W  opcode stored for commit.
- disp_rd  in  RD_W  destination register.
- disp_wb  in  1  entry writes the register file at commit.
- disp_store  in  1  entry is a store.
- disp_branch  in  1  entry is a conditional branch.
- disp_pred  in  1  predicted direction (1 = taken).
- disp_alt_addr  in  DATA_W  recovery address for a branch; stored in the data field.
- disp_done  in  1  entry is ready at dispatch (hlt, jal).
- disp_exc  in  1  entry carries an exception.
- cdb_valid  in  NCDB  per-channel valid.
- cdb_tag  in  NCDB*TAG_W  per-channel tag; channel c occupies bits [c*TAG_W +: TAG_W].
- cdb_data  in  NCDB*DATA_W  per-channel result.
- cdb_taken  in  NCDB  per-channel branch outcome.
- rp_tag  in  2*TAG_W  two operand lookup tags.
- rp_data  out  2*DATA_W  looked-up values.
- rp_ready  out  2  looked-up ready bits.
- commit_valid  out  1  one-cycle retire strobe.
- commit_opcode  out  OPC_W  opcode of the retiring entry.
- commit_rd  out  RD_W  destination of the retiring entry.
- commit_data  out  DATA_W  result of the retiring entry.
- commit_wb  out  1  register-file write enable for the retiring entry.
- commit_store  out  1  store release for the retiring entry.
- flush  out  1  one-cycle mispredict flush.
- flush_addr  out  DATA_W  redirect address accompanying flush.
- exception  out  1  head entry is busy and excepted; level signal.
- speculative  out  1  any busy, unresolved branch is present.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State:
  - head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
  - Per entry: busy, ready, branch, pred, mispred, exc, wb, store, opcode, rd, data.
- Dispatch: when disp_valid & disp_ready, write the entry at tail.
  - busy=1, ready=disp_done, mispred=0.
  - data=disp_alt_addr.
  - Increment tail.
- CDB: for each channel with cdb_valid and tag≠0 whose entry is busy and not ready:
  - Set ready.
  - Non-branch entry: data takes cdb_data.
  - Branch entry: data is kept, and mispred = cdb_taken ^ pred.
  - Writes to non-busy entries, already-ready entries, or tag 0 are ignored.
  - Two channels carrying the same tag: the lower channel index wins.
- Commit: evaluated on registered state.
  - If the head entry is busy, ready, not excepted and not mispredicted:
    - Pulse commit_valid with that entry's fields.
    - Clear busy and advance head.
  - Branches commit with commit_wb=0 and commit_store=0.
- Flush: if the head entry is busy, ready, a branch and mispredicted:
  - Pulse flush with flush_addr = that entry's data; commit_valid stays 0.
  - Clear every busy bit and set head=tail=0, count=0.
  - A dispatch in the same cycle is dropped.
  - Upstream must discard tags issued before the flush.
- Exception: an excepted head entry never commits. It holds exception high and stalls retirement until rst.
- Simultaneous dispatch and commit: count is unchanged. disp_ready is derived from the pre-edge count, so a full ROB rejects dispatch even while committing.
- Read ports:
  - rp_data = entry(tag−1).data and rp_ready = entry(tag−1).ready.
  - Tag 0 returns ready=0 and data=0.

## Timing
- Reset (asynchronous) clears all busy/ready/exc/mispred bits, head, tail and count.
- All outputs reset to 0 except empty=1 and disp_ready=1; disp_tag resets to 1.
- disp_tag, disp_ready, full, empty, speculative, exception and rp_* are combinational from state.
- commit_* and flush/flush_addr are registered and last exactly one cycle.
- Latency:
  - A CDB write at edge N sets ready at N.
  - The earliest commit pulse is visible after edge N+1.
  - A disp_done entry dispatched at edge N at an empty head commits after edge N+1.
- Throughput: one dispatch and one commit per cycle.
- Wrap-around: tail and head roll from DEPTH−1 to 0; tags roll from DEPTH to 1.

## Configuration
- ROB_CDB_BYPASS_EN defined: a read port whose tag matches a valid CDB channel in the same cycle returns that cycle's cdb_data with rp_ready=1. A branch entry returns stored data.
- ROB_CDB_BYPASS_EN not defined: read ports reflect registered state only, so a value becomes visible the cycle after its CDB write.

## Test plan
- Fill: dispatch 16 entries with DEPTH=16 → full=1 and disp_ready=0 after the 16th edge; the 17th disp_valid is ignored; disp_tag sequence is 1..16.
- Out-of-order completion: dispatch tags 1–3, CDB writes tag 3 then 1 then 2 → commits in order 1, 2, 3, each one cycle apart after tag 2 completes.
- Dual CDB: both channels write tags 2 and 5 in one cycle with values 0xA and 0xB → rp lookups return 0xA/0xB ready. The same cycle with bypass enabled returns them immediately.
- Mispredict: branch tag 1 with pred=0 and alt_addr=0x40, resolved with cdb_taken=1 → flush=1 with flush_addr=0x40 for one cycle; empty=1 next cycle; the next disp_tag is 1.
- Correct prediction: branch resolved with taken=pred → commit_valid=1, commit_wb=0, no flush, speculative drops to 0.
- Reset mid-operation: assert rst with 5 busy entries and a commit pending → all outputs return to reset values asynchronously, with no commit or flush pulse.

Source files
------------

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order dispatch/commit, NCDB result channels, two operand read ports.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB results to the read ports.
module rob_multiport #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 5,
    parameter int NCDB   = 2,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 12,
    parameter int RD_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    output logic [TAG_W-1:0]         disp_tag,
    input  logic [OPC_W-1:0]         disp_opcode,
    input  logic [RD_W-1:0]          disp_rd,
    input  logic                     disp_wb,
    input  logic                     disp_store,
    input  logic                     disp_branch,
    input  logic                     disp_pred,
    input  logic [DATA_W-1:0]        disp_alt_addr,
    input  logic                     disp_done,
    input  logic                     disp_exc,
    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*TAG_W-1:0]    cdb_tag,
    input  logic [NCDB*DATA_W-1:0]   cdb_data,
    input  logic [NCDB-1:0]          cdb_taken,
    input  logic [2*TAG_W-1:0]       rp_tag,
    output logic [2*DATA_W-1:0]      rp_data,
    output logic [1:0]               rp_ready,
    output logic                     commit_valid,
    output logic [OPC_W-1:0]         commit_opcode,
    output logic [RD_W-1:0]          commit_rd,
    output logic [DATA_W-1:0]        commit_data,
    output logic                     commit_wb,
    output logic                     commit_store,
    output logic                     flush,
    output logic [DATA_W-1:0]        flush_addr,
    output logic                     exception,
    output logic                     speculative,
    output logic                     full,
    output logic                     empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, branch_q, branch_d;
    logic [DEPTH-1:0] pred_q, pred_d, mispred_q, mispred_d, exc_q, exc_d;
    logic [DEPTH-1:0] wb_q, wb_d, store_q, store_d;
    logic [OPC_W-1:0]  opcode_q [DEPTH];
    logic [OPC_W-1:0]  opcode_d [DEPTH];
    logic [RD_W-1:0]   rd_q [DEPTH];
    logic [RD_W-1:0]   rd_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic              commit_valid_q, commit_valid_d, commit_wb_q, commit_wb_d;
    logic              commit_store_q, commit_store_d, flush_q, flush_d;
    logic [OPC_W-1:0]  commit_opcode_q, commit_opcode_d;
    logic [RD_W-1:0]   commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d, flush_addr_q, flush_addr_d;

    logic do_commit, do_flush, do_disp;

    // Tags outside 1..DEPTH never name an entry.
    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        return IDX_W'(t - TAG_W'(1));
    endfunction

    assign disp_ready  = (count_q != CNT_W'(DEPTH));
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign disp_tag    = TAG_W'(tail_q) + TAG_W'(1);
    assign exception   = busy_q[head_q] & exc_q[head_q];
    assign speculative = |(busy_q & branch_q & ~ready_q);

    assign do_flush  = busy_q[head_q] & ready_q[head_q] & branch_q[head_q] & mispred_q[head_q];
    assign do_commit = busy_q[head_q] & ready_q[head_q] & ~exc_q[head_q] & ~mispred_q[head_q];
    assign do_disp   = disp_valid & disp_ready & ~do_flush;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        branch_d  = branch_q;
        pred_d    = pred_q;
        mispred_d = mispred_q;
        exc_d     = exc_q;
        wb_d      = wb_q;
        store_d   = store_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        data_d    = data_q;

        // Highest channel first so the lowest matching channel has the final say.
        for (int c = NCDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && tag_ok(cdb_tag[c*TAG_W +: TAG_W]) &&
                busy_q[tag_idx(cdb_tag[c*TAG_W +: TAG_W])] &&
                !ready_q[tag_idx(cdb_tag[c*TAG_W +: TAG_W])]) begin
                ready_d[tag_idx(cdb_tag[c*TAG_W +: TAG_W])] = 1'b1;
                if (branch_q[tag_idx(cdb_tag[c*TAG_W +: TAG_W])])
                    mispred_d[tag_idx(cdb_tag[c*TAG_W +: TAG_W])] =
                        cdb_taken[c] ^ pred_q[tag_idx(cdb_tag[c*TAG_W +: TAG_W])];
                else
                    data_d[tag_idx(cdb_tag[c*TAG_W +: TAG_W])] = cdb_data[c*DATA_W +: DATA_W];
            end
        end

        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + IDX_W'(1);
        end

        if (do_disp) begin
            busy_d[tail_q]    = 1'b1;
            ready_d[tail_q]   = disp_done;
            branch_d[tail_q]  = disp_branch;
            pred_d[tail_q]    = disp_pred;
            mispred_d[tail_q] = 1'b0;
            exc_d[tail_q]     = disp_exc;
            wb_d[tail_q]      = disp_wb;
            store_d[tail_q]   = disp_store;
            opcode_d[tail_q]  = disp_opcode;
            rd_d[tail_q]      = disp_rd;
            data_d[tail_q]    = disp_alt_addr;
            tail_d            = tail_q + IDX_W'(1);
        end

        if (do_disp && !do_commit)
            count_d = count_q + CNT_W'(1);
        else if (!do_disp && do_commit)
            count_d = count_q - CNT_W'(1);

        if (do_flush) begin
            busy_d    = '0;
            ready_d   = '0;
            mispred_d = '0;
            exc_d     = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    always_comb begin
        commit_valid_d  = do_commit;
        commit_opcode_d = do_commit ? opcode_q[head_q] : '0;
        commit_rd_d     = do_commit ? rd_q[head_q] : '0;
        commit_data_d   = do_commit ? data_q[head_q] : '0;
        commit_wb_d     = do_commit & wb_q[head_q] & ~branch_q[head_q];
        commit_store_d  = do_commit & store_q[head_q] & ~branch_q[head_q];
        flush_d         = do_flush;
        flush_addr_d    = do_flush ? data_q[head_q] : '0;
    end

    always_comb begin
        rp_data  = '0;
        rp_ready = '0;
        for (int p = 0; p < 2; p++) begin
            if (tag_ok(rp_tag[p*TAG_W +: TAG_W])) begin
                rp_data[p*DATA_W +: DATA_W] = data_q[tag_idx(rp_tag[p*TAG_W +: TAG_W])];
                rp_ready[p]                 = ready_q[tag_idx(rp_tag[p*TAG_W +: TAG_W])];
`ifdef ROB_CDB_BYPASS_EN
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == rp_tag[p*TAG_W +: TAG_W]) begin
                        rp_ready[p] = 1'b1;
                        if (!branch_q[tag_idx(rp_tag[p*TAG_W +: TAG_W])])
                            rp_data[p*DATA_W +: DATA_W] = cdb_data[c*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            branch_q        <= '0;
            pred_q          <= '0;
            mispred_q       <= '0;
            exc_q           <= '0;
            wb_q            <= '0;
            store_q         <= '0;
            opcode_q        <= '{default: '0};
            rd_q            <= '{default: '0};
            data_q          <= '{default: '0};
            commit_valid_q  <= 1'b0;
            commit_opcode_q <= '0;
            commit_rd_q     <= '0;
            commit_data_q   <= '0;
            commit_wb_q     <= 1'b0;
            commit_store_q  <= 1'b0;
            flush_q         <= 1'b0;
            flush_addr_q    <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            branch_q        <= branch_d;
            pred_q          <= pred_d;
            mispred_q       <= mispred_d;
            exc_q           <= exc_d;
            wb_q            <= wb_d;
            store_q         <= store_d;
            opcode_q        <= opcode_d;
            rd_q            <= rd_d;
            data_q          <= data_d;
            commit_valid_q  <= commit_valid_d;
            commit_opcode_q <= commit_opcode_d;
            commit_rd_q     <= commit_rd_d;
            commit_data_q   <= commit_data_d;
            commit_wb_q     <= commit_wb_d;
            commit_store_q  <= commit_store_d;
            flush_q         <= flush_d;
            flush_addr_q    <= flush_addr_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_opcode = commit_opcode_q;
    assign commit_rd     = commit_rd_q;
    assign commit_data   = commit_data_q;
    assign commit_wb     = commit_wb_q;
    assign commit_store  = commit_store_q;
    assign flush         = flush_q;
    assign flush_addr    = flush_addr_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport: expected commit/flush pulses are queued by the
// stimulus and checked by a monitor; combinational status is checked inline.
module tb_rob_multiport;
    localparam int TAG_W = 5, NCDB = 2, DATA_W = 32, OPC_W = 12, RD_W = 5;

    logic                   clk = 1'b0, rst = 1'b1;
    logic                   disp_valid = 1'b0, disp_ready;
    logic [TAG_W-1:0]       disp_tag;
    logic [OPC_W-1:0]       disp_opcode = '0;
    logic [RD_W-1:0]        disp_rd = '0;
    logic                   disp_wb = 1'b0, disp_store = 1'b0, disp_branch = 1'b0;
    logic                   disp_pred = 1'b0, disp_done = 1'b0, disp_exc = 1'b0;
    logic [DATA_W-1:0]      disp_alt_addr = '0;
    logic [NCDB-1:0]        cdb_valid = '0, cdb_taken = '0;
    logic [NCDB*TAG_W-1:0]  cdb_tag = '0;
    logic [NCDB*DATA_W-1:0] cdb_data = '0;
    logic [2*TAG_W-1:0]     rp_tag = '0;
    logic [2*DATA_W-1:0]    rp_data;
    logic [1:0]             rp_ready;
    logic                   commit_valid, commit_wb, commit_store, flush;
    logic [OPC_W-1:0]       commit_opcode;
    logic [RD_W-1:0]        commit_rd;
    logic [DATA_W-1:0]      commit_data, flush_addr;
    logic                   exception, speculative, full, empty;

    rob_multiport dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .disp_opcode(disp_opcode), .disp_rd(disp_rd), .disp_wb(disp_wb),
        .disp_store(disp_store), .disp_branch(disp_branch), .disp_pred(disp_pred),
        .disp_alt_addr(disp_alt_addr), .disp_done(disp_done), .disp_exc(disp_exc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
        .rp_tag(rp_tag), .rp_data(rp_data), .rp_ready(rp_ready),
        .commit_valid(commit_valid), .commit_opcode(commit_opcode), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_wb(commit_wb), .commit_store(commit_store),
        .flush(flush), .flush_addr(flush_addr), .exception(exception),
        .speculative(speculative), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              fl;
        logic [OPC_W-1:0]  opc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic              wb;
        logic              st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_commit(input logic [OPC_W-1:0] opc, input logic [RD_W-1:0] rd,
                               input logic [DATA_W-1:0] data, input logic wb, input logic st);
        exp_t e;
        e.fl = 1'b0; e.opc = opc; e.rd = rd; e.data = data; e.wb = wb; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic push_flush(input logic [DATA_W-1:0] addr);
        exp_t e;
        e = '0;
        e.fl = 1'b1; e.data = addr;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_disp(input logic [OPC_W-1:0] opc, input logic [RD_W-1:0] rd,
                            input logic wb, input logic st, input logic br, input logic pred,
                            input logic [DATA_W-1:0] alt, input logic done, input logic exc);
        disp_valid = 1'b1; disp_opcode = opc; disp_rd = rd; disp_wb = wb; disp_store = st;
        disp_branch = br; disp_pred = pred; disp_alt_addr = alt; disp_done = done; disp_exc = exc;
    endtask

    task automatic disp(input logic [OPC_W-1:0] opc, input logic [RD_W-1:0] rd,
                        input logic wb, input logic st, input logic br, input logic pred,
                        input logic [DATA_W-1:0] alt, input logic done, input logic exc);
        set_disp(opc, rd, wb, st, br, pred, alt, done, exc);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic cdb_set(input int ch, input logic [TAG_W-1:0] tag,
                           input logic [DATA_W-1:0] data, input logic taken);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = tag;
        cdb_data[ch*DATA_W +: DATA_W] = data;
        cdb_taken[ch] = taken;
    endtask

    task automatic cdb_clear;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; cdb_taken = '0;
    endtask

    task automatic monitor;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (commit_valid || flush)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, commit_valid, flush}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.fl) begin
                        chk("flush", {63'd0, flush}, 64'd1);
                        chk("flush_commit_quiet", {63'd0, commit_valid}, 64'd0);
                        chk("flush_addr", {32'd0, flush_addr}, {32'd0, e.data});
                    end else begin
                        chk("commit_valid", {63'd0, commit_valid}, 64'd1);
                        chk("commit_no_flush", {63'd0, flush}, 64'd0);
                        chk("commit_opcode", {52'd0, commit_opcode}, {52'd0, e.opc});
                        chk("commit_rd", {59'd0, commit_rd}, {59'd0, e.rd});
                        chk("commit_data", {32'd0, commit_data}, {32'd0, e.data});
                        chk("commit_wb_store", {62'd0, commit_wb, commit_store}, {62'd0, e.wb, e.st});
                    end
                end
            end
        end
    endtask

    task automatic chk_reset_state(input string tagname);
        chk({tagname, "_empty_full"}, {62'd0, empty, full}, 64'd2);
        chk({tagname, "_disp_ready"}, {63'd0, disp_ready}, 64'd1);
        chk({tagname, "_disp_tag"}, {59'd0, disp_tag}, 64'd1);
        chk({tagname, "_pulses"}, {62'd0, commit_valid, flush}, 64'd0);
        chk({tagname, "_exc_spec"}, {62'd0, exception, speculative}, 64'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset
        #12;
        chk_reset_state("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to DEPTH, tags 1..16, then a rejected 17th
        for (int i = 0; i < 16; i++) begin
            set_disp(12'h100 + 12'(i), 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 32'hEEEE0000, 1'b0, 1'b0);
            chk("fill_tag", {59'd0, disp_tag}, 64'(i + 1));
            tick();
        end
        disp_valid = 1'b0;
        chk("fill_full", {62'd0, full, disp_ready}, 64'd2);
        set_disp(12'hFFF, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBAD, 1'b1, 1'b0);
        tick();
        disp_valid = 1'b0;
        chk("fill_17th_dropped", {62'd0, full, empty}, 64'd2);
        chk("fill_wrap_tag", {59'd0, disp_tag}, 64'd1);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            cdb_set(0, 5'(i + 1), 32'h1000 + 32'(i), 1'b0);
            push_commit(12'h100 + 12'(i), 5'(i), 32'h1000 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        cdb_clear();
        idle(2);
        chk("drain_empty", {63'd0, empty}, 64'd1);

        // Out-of-order completion: 3, 1, 2
        for (int i = 0; i < 3; i++)
            disp(12'h200 + 12'(i), 5'(10 + i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cdb_set(0, 5'd3, 32'h33, 1'b0);
        tick();
        cdb_clear();
        rp_tag = {5'd2, 5'd3};
        #1;
        chk("ooo_rp_ready", {62'd0, rp_ready}, 64'd1);
        chk("ooo_rp_data0", {32'd0, rp_data[31:0]}, 64'h33);
        rp_tag = {5'd0, 5'd3};
        #1;
        chk("rp_tag0", {rp_data[63:32], 31'd0, rp_ready[1]}, 64'd0);
        cdb_set(0, 5'd1, 32'h11, 1'b0);
        push_commit(12'h200, 5'd10, 32'h11, 1'b1, 1'b0);
        tick();
        cdb_set(0, 5'd2, 32'h22, 1'b0);
        push_commit(12'h201, 5'd11, 32'h22, 1'b1, 1'b0);
        push_commit(12'h202, 5'd12, 32'h33, 1'b1, 1'b0);
        tick();
        cdb_clear();
        idle(4);

        // Mispredicted branch, tag 4; younger entry and a same-cycle dispatch are dropped
        chk("mis_tag", {59'd0, disp_tag}, 64'd4);
        disp(12'h300, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
        disp(12'h301, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 1'b1, 1'b0);
        chk("mis_speculative", {63'd0, speculative}, 64'd1);
        cdb_set(0, 5'd4, 32'h5555, 1'b1);
        push_flush(32'h40);
        tick();
        cdb_clear();
        set_disp(12'h302, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        disp_valid = 1'b0;
        chk("mis_empty", {63'd0, empty}, 64'd1);
        chk("mis_tag_restart", {59'd0, disp_tag}, 64'd1);
        chk("mis_spec_clear", {63'd0, speculative}, 64'd0);
        idle(2);

        // Dual CDB, tags 2 and 5
        for (int i = 0; i < 5; i++)
            disp(12'h400 + 12'(i), 5'(20 + i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cdb_set(0, 5'd2, 32'hA, 1'b0);
        cdb_set(1, 5'd5, 32'hB, 1'b0);
        rp_tag = {5'd5, 5'd2};
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("dual_bypass_ready", {62'd0, rp_ready}, 64'd3);
        chk("dual_bypass_data", rp_data, {32'hB, 32'hA});
`else
        chk("dual_same_cycle_ready", {62'd0, rp_ready}, 64'd0);
`endif
        tick();
        cdb_clear();
        #1;
        chk("dual_ready", {62'd0, rp_ready}, 64'd3);
        chk("dual_data", rp_data, {32'hB, 32'hA});
        cdb_set(0, 5'd3, 32'h77, 1'b0);
        cdb_set(1, 5'd3, 32'h88, 1'b0);
        tick();
        cdb_clear();
        cdb_set(0, 5'd2, 32'hDEAD, 1'b0);
        tick();
        cdb_clear();
        rp_tag = {5'd3, 5'd2};
        #1;
        chk("same_tag_low_wins", rp_data, {32'h77, 32'hA});
        cdb_set(0, 5'd1, 32'h111, 1'b0);
        cdb_set(1, 5'd4, 32'h444, 1'b0);
        push_commit(12'h400, 5'd20, 32'h111, 1'b1, 1'b0);
        push_commit(12'h401, 5'd21, 32'hA, 1'b1, 1'b0);
        push_commit(12'h402, 5'd22, 32'h77, 1'b1, 1'b0);
        push_commit(12'h403, 5'd23, 32'h444, 1'b1, 1'b0);
        push_commit(12'h404, 5'd24, 32'hB, 1'b1, 1'b0);
        tick();
        cdb_clear();
        idle(6);

        // Correctly predicted branch (tag 6) then a store
        chk("pred_tag", {59'd0, disp_tag}, 64'd6);
        disp(12'h500, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
        chk("pred_speculative", {63'd0, speculative}, 64'd1);
        cdb_set(0, 5'd6, 32'h999, 1'b1);
        push_commit(12'h500, 5'd7, 32'h80, 1'b0, 1'b0);
        tick();
        cdb_clear();
        chk("pred_spec_drop", {63'd0, speculative}, 64'd0);
        push_commit(12'h501, 5'd0, 32'h1234, 1'b0, 1'b1);
        disp(12'h501, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 1'b1, 1'b0);
        idle(3);

        // Excepted head never retires
        disp(12'h600, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("exc_level", {63'd0, exception}, 64'd1);
        idle(3);
        chk("exc_held", {62'd0, exception, empty}, 64'd2);
        rst = 1'b1;
        #1;
        chk("exc_reset", {63'd0, exception}, 64'd0);
        tick();
        rst = 1'b0;

        // Asynchronous reset with 5 busy entries and a commit pending
        for (int i = 0; i < 5; i++)
            disp(12'h700 + 12'(i), 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cdb_set(0, 5'd1, 32'h71, 1'b0);
        tick();
        cdb_clear();
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        tick();
        rst = 1'b0;
        idle(3);
        chk("midrst_after", {62'd0, empty, commit_valid}, 64'd2);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
